// File: rtl/axis_dest_demux.sv
// AXI-Stream demux: routes whole packets to one of M_COUNT ports by head-beat tdest.
// Optional per-port packet counters are enabled by defining DEMUX_PKT_COUNTER_EN.
module axis_dest_demux #(
    parameter int unsigned AXIS_DATA_WIDTH = 64,
    parameter int unsigned AXIS_KEEP_WIDTH = AXIS_DATA_WIDTH / 8,
    parameter int unsigned AXIS_DEST_WIDTH = 3,
    parameter int unsigned M_COUNT         = 4,
    parameter int unsigned CNT_WIDTH       = 32
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [AXIS_DATA_WIDTH-1:0]           s_axis_tdata,
    input  logic [AXIS_KEEP_WIDTH-1:0]           s_axis_tkeep,
    input  logic                                 s_axis_tlast,
    input  logic [AXIS_DEST_WIDTH-1:0]           s_axis_tdest,
    input  logic                                 s_axis_tvalid,
    output logic                                 s_axis_tready,
    output logic [M_COUNT*AXIS_DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [M_COUNT*AXIS_KEEP_WIDTH-1:0]   m_axis_tkeep,
    output logic [M_COUNT-1:0]                   m_axis_tlast,
    output logic [M_COUNT-1:0]                   m_axis_tvalid,
    input  logic [M_COUNT-1:0]                   m_axis_tready,
    input  logic [M_COUNT-1:0]                   port_enable,
    input  logic                                 rst_counters,
    output logic [CNT_WIDTH-1:0]                 drop_counter,
    output logic [1:0]                           state,
    output logic                                 busy
`ifdef DEMUX_PKT_COUNTER_EN
    ,
    output logic [M_COUNT*CNT_WIDTH-1:0]         pkt_counter
`endif
);

    typedef enum logic [1:0] {
        StHead    = 2'd0,
        StForward = 2'd1,
        StDrop    = 2'd2
    } state_e;

    state_e                     state_q, state_d;
    logic [AXIS_DEST_WIDTH-1:0] sel_q, sel_d;
    logic [CNT_WIDTH-1:0]       drop_q;
    logic                       drop_inc;
    logic [M_COUNT-1:0]         head_oh;
    logic [M_COUNT-1:0]         fwd_oh;
    logic                       route_ok;

    assign m_axis_tdata = {M_COUNT{s_axis_tdata}};
    assign m_axis_tkeep = {M_COUNT{s_axis_tkeep}};
    assign m_axis_tlast = {M_COUNT{s_axis_tlast}};

    // Out-of-range tdest never matches any port, so it falls through to the drop path.
    always_comb begin
        head_oh = '0;
        fwd_oh  = '0;
        for (int unsigned i = 0; i < M_COUNT; i++) begin
            head_oh[i] = (s_axis_tdest == AXIS_DEST_WIDTH'(i)) && port_enable[i];
            fwd_oh[i]  = (sel_q == AXIS_DEST_WIDTH'(i));
        end
    end

    assign route_ok = |head_oh;

    always_comb begin
        state_d       = state_q;
        sel_d         = sel_q;
        drop_inc      = 1'b0;
        s_axis_tready = 1'b0;
        m_axis_tvalid = '0;
        unique case (state_q)
            StHead: begin
                if (route_ok) begin
                    m_axis_tvalid = head_oh & {M_COUNT{s_axis_tvalid}};
                    s_axis_tready = |(head_oh & m_axis_tready);
                    if (s_axis_tvalid && s_axis_tready && !s_axis_tlast) begin
                        sel_d   = s_axis_tdest;
                        state_d = StForward;
                    end
                end else begin
                    s_axis_tready = 1'b1;
                    if (s_axis_tvalid) begin
                        drop_inc = 1'b1;
                        if (!s_axis_tlast) state_d = StDrop;
                    end
                end
            end
            StForward: begin
                m_axis_tvalid = fwd_oh & {M_COUNT{s_axis_tvalid}};
                s_axis_tready = |(fwd_oh & m_axis_tready);
                if (s_axis_tvalid && s_axis_tready && s_axis_tlast) state_d = StHead;
            end
            StDrop: begin
                s_axis_tready = 1'b1;
                if (s_axis_tvalid && s_axis_tlast) state_d = StHead;
            end
            default: state_d = StHead;
        endcase
        // Nothing is accepted or presented while reset is held.
        if (rst) begin
            s_axis_tready = 1'b0;
            m_axis_tvalid = '0;
            drop_inc      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StHead;
            sel_q   <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            if (rst_counters) begin
                drop_q <= '0;
            end else if (drop_inc) begin
                drop_q <= drop_q + CNT_WIDTH'(1);
            end
        end
    end

    assign drop_counter = drop_q;
    assign state        = state_q;
    assign busy         = (state_q != StHead);

`ifdef DEMUX_PKT_COUNTER_EN
    logic [CNT_WIDTH-1:0] pkt_q [M_COUNT];

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < M_COUNT; i++) begin
            if (rst || rst_counters) begin
                pkt_q[i] <= '0;
            end else if (m_axis_tvalid[i] && m_axis_tready[i] && s_axis_tlast) begin
                pkt_q[i] <= pkt_q[i] + CNT_WIDTH'(1);
            end
        end
    end

    always_comb begin
        pkt_counter = '0;
        for (int unsigned i = 0; i < M_COUNT; i++) begin
            pkt_counter[i*CNT_WIDTH +: CNT_WIDTH] = pkt_q[i];
        end
    end
`endif

endmodule

// File: doc/axis_dest_demux.md
Name: axis_dest_demux

Overview:
- Downstream stage of the packet dispatcher FSM: consumes its AXI-Stream output (tdata/tkeep/tlast/tdest) and routes each packet whole to one of M_COUNT output streams selected by tdest.
- Route is latched on the first beat and held for the entire packet.
- Packets whose tdest is out of range or points at a host-disabled port are drained and counted as drops.
- Sits between the dispatcher and the per-destination processing cores.

Parameters:
- AXIS_DATA_WIDTH, 64, beat data width
- AXIS_KEEP_WIDTH, AXIS_DATA_WIDTH/8, tkeep width
- AXIS_DEST_WIDTH, 3, tdest width
- M_COUNT, 4, number of output ports (1..2^AXIS_DEST_WIDTH)
- CNT_WIDTH, 32, width of drop and packet counters

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- s_axis_tdata  in  AXIS_DATA_WIDTH  input data
- s_axis_tkeep  in  AXIS_KEEP_WIDTH  input keep
- s_axis_tlast  in  1  input last
- s_axis_tdest  in  AXIS_DEST_WIDTH  destination; sampled on head beat only
- s_axis_tvalid  in  1  input valid
- s_axis_tready  out  1  input ready
- m_axis_tdata  out  M_COUNT*AXIS_DATA_WIDTH  flattened; port i at slice i
- m_axis_tkeep  out  M_COUNT*AXIS_KEEP_WIDTH  flattened keep
- m_axis_tlast  out  M_COUNT  per-port last
- m_axis_tvalid  out  M_COUNT  per-port valid
- m_axis_tready  in  M_COUNT  per-port ready
- port_enable  in  M_COUNT  host mask; 0 means packets to that port are dropped
- rst_counters  in  1  synchronous clear of all counters
- drop_counter  out  CNT_WIDTH  count of dropped packets
- state  out  2  FSM state, for debug
- busy  out  1  high while a packet is in flight (state != HEAD)

Behaviour:
- Reset values:
  - state=HEAD, sel_reg=0, drop_counter=0, busy=0.
  - All m_axis_tvalid=0, s_axis_tready=0 (combinational from state).
- States: HEAD=0, FORWARD=1, DROP=2. Encoding 3 is illegal and returns to HEAD.
- Zero-latency combinational datapath:
  - tdata/tkeep/tlast are broadcast to all ports.
  - Only the selected port's tvalid is asserted.
- HEAD:
  - Route check: sel=s_axis_tdest; route OK iff sel<M_COUNT and port_enable[sel]=1.
  - Route OK: m_axis_tvalid[sel]=s_axis_tvalid, s_axis_tready=m_axis_tready[sel].
    - Transfer without tlast: sel_reg<=sel, go to FORWARD.
    - Transfer with tlast (single-beat packet): stay in HEAD.
  - Route not OK: s_axis_tready=1, no m_axis_tvalid asserted.
    - On transfer: drop_counter+1.
    - If not tlast: go to DROP.
- FORWARD:
  - Port sel_reg is used; s_axis_tdest and port_enable are ignored.
  - s_axis_tready=m_axis_tready[sel_reg].
  - Transfer with tlast returns to HEAD.
  - Deasserting port_enable mid-packet does not truncate the packet.
- DROP:
  - s_axis_tready=1, no outputs valid.
  - Transfer with tlast returns to HEAD.
  - Counter already incremented at the head beat; each packet counts once.
- tvalid deasserted in any state: hold state; no counter change.
- Counters wrap at 2^CNT_WIDTH.
- rst_counters has priority over a same-cycle increment: the result is 0.
- rst mid-packet: returns to HEAD immediately. The next beat is treated as a head beat and its tdest is sampled.
- No AXIS_DATA_WIDTH-dependent arithmetic; sel compare is done on the full AXIS_DEST_WIDTH.

Optional Feature:
- Macro: DEMUX_PKT_COUNTER_EN.
- Defined:
  - Adds output port pkt_counter (M_COUNT*CNT_WIDTH, flattened).
  - Entry i increments on each tlast transfer on m_axis port i.
  - Reset to 0 by rst; cleared by rst_counters with priority over increment.
- Undefined: port and counters absent; the remaining behaviour is identical.

Test Plan:
- Routing, ready, and back-pressure:
  - Stimulus: M_COUNT=4, port_enable=4'b1111; 3-beat packet, tdest=2; m_axis_tready[2] low for 2 cycles mid-packet.
  - Response: beats appear only on port 2, in order, with tlast on beat 3. s_axis_tready follows m_axis_tready[2]. drop_counter=0; pkt_counter[2]=1 (with feature).
- Route latched on head beat:
  - Stimulus: 4-beat packet, tdest=1 on head, tdest=3 on beats 2–4.
  - Response: all 4 beats on port 1; port 3 tvalid never asserted.
- Drop paths:
  - Stimulus: tdest=5 with M_COUNT=4 (5-beat packet); then tdest=0 with port_enable[0]=0 (1-beat packet).
  - Response: s_axis_tready=1 throughout. No m_axis_tvalid asserted. drop_counter=2; state back to HEAD after each tlast.
- Back-to-back and single-beat packets:
  - Stimulus: single-beat tdest=0, then single-beat tdest=3, then 2-beat tdest=1, continuous tvalid, all ready=1.
  - Response: one beat per cycle on ports 0, 3, 1, 1, no bubbles. State stays in HEAD except for 1 cycle in FORWARD.
- Clear/reset priority:
  - Stimulus: rst_counters asserted in the same cycle as a dropped head beat; later rst asserted during beat 2 of a forward packet, followed by a new head with tdest=3.
  - Response: drop_counter=0 after the clear. After rst, the next beat routes to port 3 and no stale sel_reg is used.
